// File: rtl/seq_divider_8by4.sv
// Sequential 8-bit by 4-bit unsigned restoring divider.
// One quotient bit per cycle, MSB first; a zero divisor short-cuts straight to DONE.
module seq_divider_8by4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  dvd_sh;
  logic [3:0]  dvs_r;
  logic [4:0]  prem;
  logic [7:0]  quo_sh;
  logic [2:0]  cnt;
  logic [4:0]  prem_nxt;
  logic        qbit;

  // One restoring step: returns {quotient bit, new partial remainder}.
  // The remainder entering a step is always < divisor <= 15, so the shifted
  // trial value stays below 31 and fits the 5-bit partial remainder.
  function automatic logic [5:0] restore_step(input logic [4:0] pr,
                                              input logic       din,
                                              input logic [3:0] d);
    logic [4:0] trial;
    trial = {pr[3:0], din};
    if (trial >= {1'b0, d})
      return {1'b1, trial - {1'b0, d}};
    else
      return {1'b0, trial};
  endfunction

  always_comb begin
    {qbit, prem_nxt} = restore_step(prem, dvd_sh[7], dvs_r);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (divisor == 4'd0) ? DONE : CALC;
      CALC: if (cnt == 3'd0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_sh      <= 8'd0;
      dvs_r       <= 4'd0;
      prem        <= 5'd0;
      quo_sh      <= 8'd0;
      cnt         <= 3'd0;
      quotient    <= 8'd0;
      remainder   <= 4'd0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd_sh <= dividend;
            dvs_r  <= divisor;
            prem   <= 5'd0;
            quo_sh <= 8'd0;
            cnt    <= 3'd7;
            if (divisor == 4'd0) begin
              quotient    <= 8'hFF;
              remainder   <= 4'd0;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          prem   <= prem_nxt;
          dvd_sh <= {dvd_sh[6:0], 1'b0};
          quo_sh <= {quo_sh[6:0], qbit};
          cnt    <= cnt - 3'd1;
          if (cnt == 3'd0) begin
            quotient    <= {quo_sh[6:0], qbit};
            remainder   <= prem_nxt[3:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Directed bench for seq_divider_8by4: corner vectors, protocol cases and a full operand sweep.
module tb_seq_divider_8by4;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int total = 0;
  int bad   = 0;

  seq_divider_8by4 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the accepting edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 30) begin
      step();
      lat++;
    end
  endtask

  task automatic run(input logic [7:0] a, input logic [3:0] b, input string tag,
                     input logic [7:0] eq, input logic [3:0] er, input logic ez);
    int lat;
    start = 1'b1; dividend = a; divisor = b;
    step();
    start = 1'b0; dividend = 8'h5A; divisor = 4'hC;
    wait_done(lat);
    chk({tag, "_lat"}, lat, (b == 4'd0) ? 1 : 9);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, ez);
    step();
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold_q"}, quotient, eq);
  endtask

  initial begin
    int lat, nbusy, ndone;
    rst = 1'b1; start = 1'b1; dividend = 8'd6; divisor = 4'd2;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b0; start = 1'b0;
    step();

    run(8'd6,   4'd2,  "6div2",    8'd3,   4'd0, 1'b0);
    run(8'd200, 4'd7,  "200div7",  8'd28,  4'd4, 1'b0);
    run(8'd225, 4'd15, "225div15", 8'd15,  4'd0, 1'b0);
    run(8'd255, 4'd1,  "255div1",  8'd255, 4'd0, 1'b0);
    run(8'd81,  4'd9,  "81div9",   8'd9,   4'd0, 1'b0);
    run(8'd100, 4'd0,  "100div0",  8'hFF,  4'd0, 1'b1);
    run(8'd10,  4'd3,  "10div3",   8'd3,   4'd1, 1'b0);
    run(8'd7,   4'd12, "7div12",   8'd0,   4'd7, 1'b0);

    // start pulsed mid-calculation with new operands must be ignored
    start = 1'b1; dividend = 8'd50; divisor = 4'd5;
    step();
    start = 1'b0;
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 14; i++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      if (i == 2) begin start = 1'b1; dividend = 8'd99; divisor = 4'd4; end
      else if (i == 3) begin start = 1'b0; dividend = 8'd1; divisor = 4'd1; end
      step();
    end
    chk("ign_busy_cycles", nbusy, 9);
    chk("ign_done_count", ndone, 1);
    chk("ign_q", quotient, 10);
    chk("ign_r", remainder, 0);

    // reset in the 4th CALC cycle aborts with no done
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("abort_in_calc", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) ndone++;
      step();
    end
    chk("abort_quiet", ndone, 0);
    run(8'd6, 4'd2, "post_abort", 8'd3, 4'd0, 1'b0);

    // start held high: back-to-back operations one IDLE cycle apart
    start = 1'b1; dividend = 8'd81; divisor = 4'd9;
    step();
    wait_done(lat);
    chk("b2b_lat1", lat, 9);
    chk("b2b_q1", quotient, 9);
    dividend = 8'd225; divisor = 4'd15;
    step();
    chk("b2b_idle_gap", busy, 0);
    step();
    chk("b2b_restart", busy, 1);
    start = 1'b0;
    wait_done(lat);
    chk("b2b_lat2", lat, 9);
    chk("b2b_q2", quotient, 15);
    chk("b2b_r2", remainder, 0);
    step();

    // full operand sweep against integer division
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        start = 1'b1; dividend = 8'(a); divisor = 4'(b);
        step();
        start = 1'b0;
        wait_done(lat);
        chk("sweep_lat", lat, (b == 0) ? 1 : 9);
        chk("sweep_q", quotient, (b == 0) ? 255 : a / b);
        chk("sweep_r", remainder, (b == 0) ? 0 : a % b);
        chk("sweep_dbz", div_by_zero, (b == 0) ? 1 : 0);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider_8by4.md
SEQ_DIVIDER_8BY4 -- requirements
Module: seq_divider_8by4

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: dividend 8 bits, divisor 4 bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a division; sampled on clk.
REQ-005 dividend  input  8  unsigned dividend; sampled only on the edge that accepts start.
REQ-006 divisor  input  4  unsigned divisor; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high whenever the state is not IDLE.
REQ-008 done  output  1  single-cycle pulse; results are valid while it is high.
REQ-009 quotient  output  8  unsigned quotient, registered.
REQ-010 remainder  output  4  unsigned remainder, registered.
REQ-011 div_by_zero  output  1  error flag for the last completed operation, registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 In IDLE, start=1 on a rising edge SHALL accept the request and latch dividend and divisor into internal registers.
REQ-014 On acceptance with divisor!=0, the next state SHALL be CALC and the bit counter SHALL be loaded with 7.
REQ-015 On acceptance with divisor==0, the next state SHALL be DONE, skipping CALC entirely.
REQ-016 CALC SHALL perform restoring division, one quotient bit per cycle, MSB first, over exactly 8 cycles.
REQ-017 Each CALC cycle SHALL do the following:
  - partial remainder (5 bits) = {partial remainder[3:0], next dividend bit};
  - if the partial remainder >= divisor: subtract the divisor and set the quotient bit to 1;
  - otherwise: leave the partial remainder unchanged and set the quotient bit to 0.
REQ-018 The 5-bit partial remainder SHALL never overflow.
REQ-019 After the CALC cycle with counter==0, the next state SHALL be DONE.
REQ-020 quotient, remainder and div_by_zero SHALL be updated on the same edge that enters DONE.
REQ-021 Latency for divisor!=0: done SHALL be high in the cycle beginning 9 rising edges after the accepting edge (1 load edge + 8 CALC edges).
REQ-022 Latency for divisor==0: done SHALL be high in the cycle immediately after the accepting edge.
REQ-023 Divide-by-zero results SHALL be quotient=8'hFF, remainder=4'h0, div_by_zero=1.
REQ-024 A normal completion SHALL clear div_by_zero to 0.
REQ-025 DONE SHALL last exactly one cycle; the next state SHALL always be IDLE.
REQ-026 done SHALL be high only in the DONE state.
REQ-027 quotient, remainder and div_by_zero SHALL hold their values until the next completion or reset.
REQ-028 start while in CALC or DONE SHALL be ignored, and the operands in flight SHALL NOT change.
REQ-029 start held high continuously SHALL start a new operation on the first IDLE edge after DONE, giving back-to-back operations 1 IDLE cycle apart.
REQ-030 Input changes on dividend or divisor after acceptance SHALL NOT affect the result.
REQ-031 Results SHALL satisfy dividend == quotient*divisor + remainder, with remainder < divisor, for every divisor in 1..15.

Reset
REQ-032 rst=1 SHALL force the next state to IDLE regardless of the current state.
REQ-033 rst=1 SHALL clear quotient, remainder, div_by_zero, busy, done, the counter and all internal registers to 0.
REQ-034 rst SHALL take priority over start on the same edge.
REQ-035 Reset during CALC SHALL abort the operation; done SHALL NOT assert for the aborted operation.
REQ-036 After rst deasserts, the first start SHALL be accepted on the first rising edge at which rst=0 and start=1.

Verification
REQ-037 Normal division, small operands: dividend=6, divisor=2 -> exactly 9 edges after accept, done=1 for one cycle, quotient=3, remainder=0, div_by_zero=0.
REQ-038 Remainder cases:
  - 200/7 -> quotient=28, remainder=4;
  - 225/15 -> quotient=15, remainder=0;
  - 255/1 -> quotient=255, remainder=0;
  - 81/9 -> quotient=9, remainder=0.
REQ-039 Divide by zero: dividend=100, divisor=0 -> done high on the cycle after accept; quotient=8'hFF, remainder=0, div_by_zero=1; a following 10/3 gives quotient=3, remainder=1, div_by_zero=0.
REQ-040 Start ignored while busy: start 50/5, then pulse start with 99/4 during CALC and change the inputs -> exactly one done, with quotient=10, remainder=0; busy stays high for 9 cycles.
REQ-041 Reset mid-operation: start 200/7, assert rst on the 4th CALC cycle -> all outputs 0 and state IDLE next cycle, no done pulse; a subsequent 6/2 completes correctly.
REQ-042 Exhaustive sweep of all 4096 operand pairs: each result checked against the reference model of REQ-031 and REQ-023, with done latency checked per REQ-021 and REQ-022.
